// File: rtl/coeff_write_buffer_pkg.sv
// Shared constants and state encoding for the sampler-to-SRAM coefficient write buffer.
package coeff_write_buffer_pkg;

    localparam int unsigned COEFF_W        = 12;
    localparam int unsigned SAMPLE_W       = 4 * COEFF_W;
    localparam int unsigned WORD_ADDR_W    = 6;
    localparam int unsigned POLY_BASE_W    = 3;
    localparam int unsigned FIFO_DEPTH     = 4;
    localparam int unsigned WORDS_PER_POLY = 64;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE   = 2'd0;
    localparam state_t ST_ACTIVE = 2'd1;
    localparam state_t ST_DONE   = 2'd2;

endpackage

// File: rtl/coeff_write_buffer_sync_fifo.sv
// Small synchronous FIFO with occupancy count; caller guarantees no push when full
// without a same-cycle pop, and no pop when empty.
module coeff_write_buffer_sync_fifo #(
    parameter int unsigned WIDTH = 54,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       resetb,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           wdata_i,
    input  logic                       pop_i,
    output logic [WIDTH-1:0]           rdata_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_i) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop_i)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        case ({push_i, pop_i})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetb) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is not reset; readers qualify the head with empty_o.
    always_ff @(posedge clk) begin
        if (push_i) mem_q[wr_ptr_q] <= wdata_i;
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;

endmodule

// File: rtl/coeff_write_buffer.sv
// Buffers sampler words and streams them into one polynomial slot of the shared SRAM,
// signalling completion after a full polynomial and asserting hold before the FIFO fills.
module coeff_write_buffer
    import coeff_write_buffer_pkg::*;
#(
    parameter int unsigned DATA_W = SAMPLE_W,
    parameter int unsigned ADDR_W = WORD_ADDR_W,
    parameter int unsigned BASE_W = POLY_BASE_W,
    parameter int unsigned DEPTH  = FIFO_DEPTH,
    parameter int unsigned WORDS  = WORDS_PER_POLY
) (
    input  logic                       clk,
    input  logic                       resetb,
    input  logic                       start,
    input  logic [BASE_W-1:0]          poly_base,
    input  logic [DATA_W-1:0]          sample_in,
    input  logic [ADDR_W-1:0]          sample_addr,
    input  logic                       sample_valid,
    output logic                       hold,
    output logic                       sram_we,
    output logic [BASE_W+ADDR_W-1:0]   sram_addr,
    output logic [DATA_W-1:0]          sram_wdata,
    input  logic                       sram_ready,
    output logic                       busy,
    output logic                       poly_done,
    output logic                       overflow
);

    localparam int unsigned CNT_W  = $clog2(WORDS) + 1;
    localparam int unsigned OCC_W  = $clog2(DEPTH) + 1;
    localparam int unsigned FIFO_W = ADDR_W + DATA_W;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    push_cnt_q, push_cnt_d;
    logic [CNT_W-1:0]    wr_cnt_q, wr_cnt_d;
    logic [BASE_W-1:0]   base_q, base_d;
    logic                overflow_q, overflow_d;

    logic                fifo_push;
    logic                fifo_pop;
    logic                fifo_full;
    logic                fifo_empty;
    logic [OCC_W-1:0]    fifo_count;
    logic [FIFO_W-1:0]   fifo_rdata;

    assign busy      = (state_q != ST_IDLE);
    assign poly_done = (state_q == ST_DONE);
    assign overflow  = overflow_q;
    assign hold      = (fifo_count >= OCC_W'(DEPTH - 1));
    assign sram_we   = !fifo_empty && busy;
    assign fifo_pop  = sram_we && sram_ready;

    // Head is gated so the write port reads as zero whenever no request is pending.
    assign sram_addr  = sram_we ? {base_q, fifo_rdata[FIFO_W-1 -: ADDR_W]} : '0;
    assign sram_wdata = sram_we ? fifo_rdata[DATA_W-1:0] : '0;

    always_comb begin
        state_d    = state_q;
        push_cnt_d = push_cnt_q;
        wr_cnt_d   = wr_cnt_q;
        base_d     = base_q;
        overflow_d = overflow_q;
        fifo_push  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d    = ST_ACTIVE;
                    push_cnt_d = '0;
                    wr_cnt_d   = '0;
                    overflow_d = 1'b0;
                    base_d     = poly_base;
                end
            end
            ST_ACTIVE: begin
                if (sample_valid) begin
                    if ((push_cnt_q < CNT_W'(WORDS)) && (!fifo_full || fifo_pop)) begin
                        fifo_push  = 1'b1;
                        push_cnt_d = push_cnt_q + CNT_W'(1);
                    end else begin
                        overflow_d = 1'b1;
                    end
                end
                if (fifo_pop && (wr_cnt_q == CNT_W'(WORDS - 1))) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (fifo_pop) wr_cnt_d = wr_cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (!resetb) begin
            state_q    <= ST_IDLE;
            push_cnt_q <= '0;
            wr_cnt_q   <= '0;
            base_q     <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            push_cnt_q <= push_cnt_d;
            wr_cnt_q   <= wr_cnt_d;
            base_q     <= base_d;
            overflow_q <= overflow_d;
        end
    end

    coeff_write_buffer_sync_fifo #(
        .WIDTH (FIFO_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .resetb  (resetb),
        .push_i  (fifo_push),
        .wdata_i ({sample_addr, sample_in}),
        .pop_i   (fifo_pop),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

endmodule
